// File: rtl/vec_issue_pkg.sv
// Shared types for the vector instruction issue queue: FSM states and the
// buffered {instruction, rs1, rs2} entry.
package vec_issue_pkg;

  localparam int unsigned ISSUE_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [ISSUE_XLEN-1:0] inst;
    logic [ISSUE_XLEN-1:0] rs1;
    logic [ISSUE_XLEN-1:0] rs2;
  } issue_entry_t;

endpackage

// File: rtl/vec_issue_fifo.sv
// DEPTH-entry FIFO of issue entries with occupancy count; full blocks pushes
// regardless of a same-cycle pop.
module vec_issue_fifo
  import vec_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  issue_entry_t     push_data_i,
  input  logic             pop_i,
  output issue_entry_t     pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  issue_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/vec_inst_issue_queue.sv
// Buffers vector instructions with operand snapshots and issues them one at a
// time to the datapath, flagging illegal and hung instructions.
module vec_inst_issue_queue
  import vec_issue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned XLEN    = ISSUE_XLEN,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [XLEN-1:0]  s_instruction,
  input  logic [XLEN-1:0]  s_rs1_data,
  input  logic [XLEN-1:0]  s_rs2_data,
  output logic [XLEN-1:0]  dp_instruction,
  output logic [XLEN-1:0]  dp_rs1_data,
  output logic [XLEN-1:0]  dp_rs2_data,
  output logic             dp_start,
  input  logic             dp_is_vec,
  input  logic             dp_inst_done,
  output logic             retire,
  output logic             illegal_inst,
  output logic             timeout_err,
  output logic             busy,
  output logic [CNT_W-1:0] q_count
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  issue_state_e     state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  issue_entry_t     issue_q, issue_d;
  logic             retire_q, retire_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  issue_entry_t     push_entry, head_entry;
  logic             fifo_full, fifo_empty, pop;

  assign push_entry = '{inst: s_instruction, rs1: s_rs1_data, rs2: s_rs2_data};

  vec_issue_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (s_valid),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (q_count)
  );

  // The issue register is cleared on every exit so dp_* read 0 while idle.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    issue_d   = issue_q;
    retire_d  = 1'b0;
    illegal_d = 1'b0;
    timeout_d = timeout_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          issue_d = head_entry;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!dp_is_vec) begin
          illegal_d = 1'b1;
          issue_d   = '0;
          state_d   = IDLE;
        end else if (dp_inst_done) begin
          retire_d = 1'b1;
          issue_d  = '0;
          state_d  = IDLE;
        end else begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (dp_inst_done) begin
          retire_d = 1'b1;
          issue_d  = '0;
          state_d  = IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          issue_d   = '0;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      issue_q   <= '0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      issue_q   <= issue_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign s_ready        = !fifo_full;
  assign dp_instruction = issue_q.inst;
  assign dp_rs1_data    = issue_q.rs1;
  assign dp_rs2_data    = issue_q.rs2;
  assign dp_start       = (state_q == ISSUE);
  assign retire         = retire_q;
  assign illegal_inst   = illegal_q;
  assign timeout_err    = timeout_q;
  assign busy           = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_vec_inst_issue_queue.sv
// Self-checking bench: table-driven single-instruction vectors plus sequences for
// fill, illegal, timeout, reset and pointer-wrap cases; scoreboard checks issue order.
module tb_vec_inst_issue_queue;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [XLEN-1:0]  s_instruction = '0, s_rs1_data = '0, s_rs2_data = '0;
  logic [XLEN-1:0]  dp_instruction, dp_rs1_data, dp_rs2_data;
  logic             dp_start, dp_is_vec;
  logic             dp_inst_done = 1'b0;
  logic             retire, illegal_inst, timeout_err, busy;
  logic [CNT_W-1:0] q_count;

  always #5 clk = ~clk;

  // Decoder stand-in: only the OP-V major opcode is a legal vector instruction.
  assign dp_is_vec = (dp_instruction[6:0] == 7'h57);

  vec_inst_issue_queue #(
    .DEPTH   (DEPTH),
    .XLEN    (XLEN),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_instruction  (s_instruction),
    .s_rs1_data     (s_rs1_data),
    .s_rs2_data     (s_rs2_data),
    .dp_instruction (dp_instruction),
    .dp_rs1_data    (dp_rs1_data),
    .dp_rs2_data    (dp_rs2_data),
    .dp_start       (dp_start),
    .dp_is_vec      (dp_is_vec),
    .dp_inst_done   (dp_inst_done),
    .retire         (retire),
    .illegal_inst   (illegal_inst),
    .timeout_err    (timeout_err),
    .busy           (busy),
    .q_count        (q_count)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } ent_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          dly;
    logic        exp_ret;
    logic        exp_ill;
  } vec_t;

  int          n_checks = 0;
  int          n_pass = 0;
  ent_t        sb[$];
  logic [31:0] ret_log[$];
  logic [31:0] ill_log[$];
  logic [31:0] last_issued = '0;
  vec_t        vecs[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_valid = 1'b0;
    dp_inst_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
    ret_log.delete();
    ill_log.delete();
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2);
    ent_t e;
    s_valid = 1'b1;
    s_instruction = inst;
    s_rs1_data = rs1;
    s_rs2_data = rs2;
    e.inst = inst;
    e.rs1 = rs1;
    e.rs2 = rs2;
    if (s_ready) sb.push_back(e);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (!dp_start && n < budget) begin
      tick();
      n++;
    end
    if (!dp_start) check("start_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic drain(input int cycles);
    dp_inst_done = 1'b1;
    repeat (cycles) tick();
    dp_inst_done = 1'b0;
  endtask

  // Scoreboard: every issue must present the oldest accepted entry.
  always @(negedge clk) begin
    if (!reset && dp_start) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_issue", dp_instruction, 32'd0);
      end else begin
        ent_t e;
        e = sb.pop_front();
        check("issue_inst", dp_instruction, e.inst);
        check("issue_rs1", dp_rs1_data, e.rs1);
        check("issue_rs2", dp_rs2_data, e.rs2);
      end
      last_issued = dp_instruction;
    end
    if (!reset && retire) ret_log.push_back(last_issued);
    if (!reset && illegal_inst) ill_log.push_back(last_issued);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    ent_t fill[5];
    ent_t wrap[5];

    vecs[0] = '{32'h0200_7057, 32'h0000_0011, 32'h0000_0022, 0, 1'b1, 1'b0};
    vecs[1] = '{32'h0220_8057, 32'hdead_beef, 32'h1234_5678, 3, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0013, 32'h0000_0001, 32'h0000_0002, 0, 1'b0, 1'b1};
    vecs[3] = '{32'h5e00_3057, 32'hcafe_f00d, 32'h0bad_cafe, TIMEOUT, 1'b1, 1'b0};

    // Reset state
    do_reset();
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_q_count", 32'(q_count), 32'd0);
    check("rst_dp_inst", dp_instruction, 32'd0);
    check("rst_dp_start", 32'(dp_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", {29'd0, retire, illegal_inst, timeout_err}, 32'd0);

    // Table: one instruction each; dly = cycles from dp_start to done
    // (TIMEOUT lands done on the last WAIT cycle, where done must beat timeout).
    for (int v = 0; v < 4; v++) begin
      push(vecs[v].inst, vecs[v].rs1, vecs[v].rs2);
      wait_start(6);
      repeat (vecs[v].dly) tick();
      dp_inst_done = 1'b1;
      tick();
      dp_inst_done = 1'b0;
      check($sformatf("vec%0d_retire", v), 32'(retire), 32'(vecs[v].exp_ret));
      check($sformatf("vec%0d_illegal", v), 32'(illegal_inst), 32'(vecs[v].exp_ill));
      check($sformatf("vec%0d_timeout", v), 32'(timeout_err), 32'd0);
      check($sformatf("vec%0d_dp_idle", v), dp_instruction, 32'd0);
      check($sformatf("vec%0d_q_count", v), 32'(q_count), 32'd0);
      tick();
    end

    // Latency N+2 and operands held for the whole instruction
    push(32'h0200_7057, 32'h0000_00a1, 32'h0000_00b2);
    check("lat_n1_no_start", 32'(dp_start), 32'd0);
    tick();
    check("lat_n2_start", 32'(dp_start), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hold_inst_%0d", i), dp_instruction, 32'h0200_7057);
      check($sformatf("hold_rs1_%0d", i), dp_rs1_data, 32'h0000_00a1);
      if (i == 3) dp_inst_done = 1'b1;
      tick();
    end
    dp_inst_done = 1'b0;
    check("lat_retire", 32'(retire), 32'd1);
    tick();
    check("lat_retire_once", 32'(retire), 32'd0);
    check("lat_q_count", 32'(q_count), 32'd0);

    // Fill: 5 accepted (one moves to issue), full refuses even with a pop
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fill[i].inst = 32'h0000_0057 | (32'(i + 1) << 20);
      fill[i].rs1 = 32'h100 + 32'(i);
      fill[i].rs2 = 32'h200 + 32'(i);
      push(fill[i].inst, fill[i].rs1, fill[i].rs2);
    end
    check("fill_accepted", 32'(sb.size()), 32'd4);
    check("fill_q_count", 32'(q_count), 32'd4);
    check("fill_s_ready", 32'(s_ready), 32'd0);
    dp_inst_done = 1'b1;
    tick();
    dp_inst_done = 1'b0;
    check("fill_pop_cycle_full", 32'(s_ready), 32'd0);
    push(32'h0990_0057, 32'h0, 32'h0);
    check("fill_refused_q_count", 32'(q_count), 32'd3);
    drain(12);
    check("fill_retired_cnt", 32'(ret_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < ret_log.size()) check($sformatf("fill_order_%0d", i), ret_log[i], fill[i].inst);
    check("fill_timeout", 32'(timeout_err), 32'd0);
    check("fill_idle", 32'(busy), 32'd0);

    // Illegal then legal: illegal pulse, no retire, next issues 2 cycles later
    do_reset();
    push(32'h0000_0013, 32'h5, 32'h6);
    push(32'h0200_7057, 32'h7, 32'h8);
    check("ill_issue_start", 32'(dp_start), 32'd1);
    tick();
    check("ill_pulse", 32'(illegal_inst), 32'd1);
    check("ill_no_retire", 32'(retire), 32'd0);
    tick();
    check("ill_next_start", 32'(dp_start), 32'd1);
    check("ill_next_inst", dp_instruction, 32'h0200_7057);
    dp_inst_done = 1'b1;
    tick();
    dp_inst_done = 1'b0;
    check("ill_next_retire", 32'(retire), 32'd1);
    check("ill_log", 32'(ill_log.size()), 32'd1);

    // Timeout: never done, error 8 cycles into WAIT, sticky, queue keeps going
    push(32'h0400_1057, 32'h9, 32'ha);
    wait_start(6);
    tick();
    repeat (TIMEOUT - 1) tick();
    check("to_not_yet", 32'(timeout_err), 32'd0);
    tick();
    check("to_set", 32'(timeout_err), 32'd1);
    check("to_no_retire", 32'(retire), 32'd0);
    check("to_dropped", dp_instruction, 32'd0);
    push(32'h0600_2057, 32'hb, 32'hc);
    wait_start(6);
    dp_inst_done = 1'b1;
    tick();
    dp_inst_done = 1'b0;
    check("to_after_retire", 32'(retire), 32'd1);
    check("to_sticky", 32'(timeout_err), 32'd1);

    // Reset in WAIT with 3 queued discards everything
    for (int i = 0; i < 4; i++) push(32'h0800_0057 + 32'(i << 12), 32'(i), 32'(i));
    check("rw_q_count", 32'(q_count), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check("rw_q_count_0", 32'(q_count), 32'd0);
    check("rw_dp_inst", dp_instruction, 32'd0);
    check("rw_dp_rs2", dp_rs2_data, 32'd0);
    check("rw_s_ready", 32'(s_ready), 32'd1);
    check("rw_timeout", 32'(timeout_err), 32'd0);
    repeat (3) tick();
    check("rw_stays_idle", {30'd0, busy, dp_start}, 32'd0);

    // Push+pop at count 2 with wr_ptr wrapping 3 -> 0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wrap[i].inst = 32'h0a00_0057 | (32'(i) << 12);
      wrap[i].rs1 = 32'h300 + 32'(i);
      wrap[i].rs2 = 32'h400 + 32'(i);
    end
    for (int i = 0; i < 3; i++) push(wrap[i].inst, wrap[i].rs1, wrap[i].rs2);
    dp_inst_done = 1'b1;
    tick();
    dp_inst_done = 1'b0;
    check("wrap_before", 32'(q_count), 32'd2);
    push(wrap[3].inst, wrap[3].rs1, wrap[3].rs2);
    check("wrap_count_kept", 32'(q_count), 32'd2);
    push(wrap[4].inst, wrap[4].rs1, wrap[4].rs2);
    drain(12);
    check("wrap_retired_cnt", 32'(ret_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < ret_log.size()) check($sformatf("wrap_order_%0d", i), ret_log[i], wrap[i].inst);
    check("wrap_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
